wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the 16-bit-data / 32-bit-address bus driven by the moxielite Wishbone wrapper.
- Lets the CPU (master 0) and a second master (debug/DMA, master 1) share the memory/peripheral slave bus.
- Grant is round-robin and held for the whole of a master's CYC.
- An optional watchdog terminates hung cycles with ERR.

---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_arb_watchdog.sv | 63 ++++++
 rtl/wb_arbiter_2m.sv | 181 ++++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   - Bus widths for the 16-bit data / 32-bit address Wishbone bus.
//   - Arbiter state encoding. The grant states double as the one-hot grant
//     vector (StGnt0 = 01, StGnt1 = 10, StIdle = 00).
//   - gnt_of(): decodes a state into the gnt_o grant vector.
package wb_arb_pkg;

  localparam int unsigned WB_DW = 16;
  localparam int unsigned WB_AW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } arb_state_e;

  function automatic logic [1:0] gnt_of(input arb_state_e st);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (st)
      StGnt0:  gnt = 2'b01;
      StGnt1:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog for wb_arbiter_2m. Counts strobe cycles the slave leaves
// unacknowledged and raises a one-cycle error pulse when the limit is hit.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous reset, active-low
//   clear_i  idle or grant changing: restart the count
//   stb_i    strobe currently presented to the slave
//   ack_i    slave acknowledge
//   err_o    registered timeout pulse, high for exactly one cycle
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o
);

  localparam logic [TMO_W-1:0] CntLast = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fire;

  // Count value TIMEOUT_CYCLES-1 with the strobe still unanswered means this
  // is the TIMEOUT_CYCLES-th unacknowledged cycle.
  assign fire = stb_i && !ack_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (stb_i && !ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (ack_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter (16-bit data, 32-bit address).
// Master 0 is the CPU, master 1 a debug/DMA master. Arbitration is
// round-robin on ties and a grant is held for the master's whole CYC, so
// block transfers and read-modify-write sequences are never split.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that ends a
// hung cycle with a one-cycle ERR to the granted master. Without it the
// m*_err_o outputs are constant 0.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   m0_* / m1_*             master-side Wishbone ports (dat/adr/sel/we/cyc/stb
//                           in, dat/ack/err out)
//   s_*                     slave-side Wishbone port
//   gnt_o                   one-hot grant: bit0 master 0, bit1 master 1
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  // master 0
  input  logic [WB_DW-1:0] m0_dat_i,
  output logic [WB_DW-1:0] m0_dat_o,
  input  logic [WB_AW-1:0] m0_adr_i,
  input  logic [1:0]       m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  // master 1
  input  logic [WB_DW-1:0] m1_dat_i,
  output logic [WB_DW-1:0] m1_dat_o,
  input  logic [WB_AW-1:0] m1_adr_i,
  input  logic [1:0]       m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  // slave
  output logic [WB_DW-1:0] s_dat_o,
  input  logic [WB_DW-1:0] s_dat_i,
  output logic [WB_AW-1:0] s_adr_o,
  output logic [1:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  localparam bit CfgOk = (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535) &&
                         ((64'(TIMEOUT_CYCLES) >> TMO_W) == 64'd0);

  if (!CfgOk) begin : g_cfg_err
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be 1..65535 and below 2**TMO_W");
  end

  arb_state_e state_q, state_d;
  // Last master to finish a cycle: 0 = master 0, 1 = master 1. Resets to 1
  // so master 0 wins the first tie.
  logic       last_gnt_q, last_gnt_d;
  logic       wd_err;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Next-state logic. A master dropping CYC hands straight over to a waiting
  // peer, so there is no idle cycle between back-to-back owners.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_gnt_q ? StGnt0 : StGnt1;
        end else if (m0_cyc_i) begin
          state_d = StGnt0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (!m0_cyc_i) begin
          last_gnt_d = 1'b0;
          state_d    = m1_cyc_i ? StGnt1 : StIdle;
        end
      end
      StGnt1: begin
        if (!m1_cyc_i) begin
          last_gnt_d = 1'b1;
          state_d    = m0_cyc_i ? StGnt0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: combinational bus mux driven by the registered state, so an
  // asynchronous reset clears every output immediately.
  always_comb begin
    s_dat_o  = '0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      StGnt0: begin
        s_dat_o  = m0_dat_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = wd_err;
      end
      StGnt1: begin
        s_dat_o  = m1_dat_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = wd_err;
      end
      default: ;
    endcase
    // The error cycle also terminates the slave-side cycle; the grant itself
    // stays until the master drops CYC.
    if (wd_err) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  assign gnt_o = gnt_of(state_q);

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_clear;

  assign wd_clear = (state_q == StIdle) || (state_d != state_q);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_W         (TMO_W)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clear_i(wd_clear),
    .stb_i  (s_stb_o),
    .ack_i  (s_ack_i),
    .err_o  (wd_err)
  );
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus randomized
// two-master traffic, checked by a scoreboard against a grant-ownership model.
module tb_wb_arbiter_2m;

  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } beat_t;

  logic        clk, rst_n;
  logic [15:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o;
  logic [31:0] m0_adr_i, m1_adr_i;
  logic [1:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [15:0] s_dat_o, s_dat_i;
  logic [31:0] s_adr_o;
  logic [1:0]  s_sel_o, gnt_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  int n_pass = 0;
  int n_total = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t mon_e;
  logic [15:0] rdata[2];

  // Reference model: which master owns the bus (-1 none) and who finished last.
  int owner;
  int last;

  // Slave model controls
  bit          slave_en;
  bit          stray_req;
  int          fixed_wait;
  bit          fixed_dat_en;
  logic [15:0] fixed_dat;
  bit          mon_en;

  wb_arbiter_2m #(
    .TIMEOUT_CYCLES(8),
    .TMO_W         (16)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o),
    .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i),
    .m0_we_i (m0_we_i),
    .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o),
    .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i),
    .m1_we_i (m1_we_i),
    .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [1:0] exp_gnt(input int own);
    return (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
  endfunction

  // Ownership rules: a free bus goes to the lone requester, or on a tie to
  // the master that did not finish last; an owner keeps it while CYC is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= -1;
      last  <= 1;
    end else if (owner == -1) begin
      if (m0_cyc_i && m1_cyc_i) owner <= (last == 1) ? 0 : 1;
      else if (m0_cyc_i)        owner <= 0;
      else if (m1_cyc_i)        owner <= 1;
    end else if (owner == 0 && !m0_cyc_i) begin
      last  <= 0;
      owner <= m1_cyc_i ? 1 : -1;
    end else if (owner == 1 && !m1_cyc_i) begin
      last  <= 1;
      owner <= m0_cyc_i ? 0 : -1;
    end
  end

  // Slave: acks a strobe after a (random or fixed) number of wait cycles.
  initial begin
    bit req;
    int wcnt;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    wcnt    = 0;
    forever begin
      @(posedge clk);
      req = s_cyc_o && s_stb_o && !s_ack_i;
      #1;
      s_ack_i = 1'b0;
      if (stray_req) begin
        s_ack_i   = 1'b1;
        stray_req = 1'b0;
      end else if (slave_en && req) begin
        if (wcnt == 0) begin
          s_ack_i = 1'b1;
          s_dat_i = fixed_dat_en ? fixed_dat : 16'($urandom);
        end else begin
          wcnt--;
        end
      end else begin
        wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: grant against the model every cycle; on each slave ACK pop the
  // owner's expected beat and compare the slave-side request and the routing.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("gnt", gnt_o, exp_gnt(owner));
      if (owner < 0) begin
        chk("idle_s_cyc", s_cyc_o, 1'b0);
        chk("idle_s_stb", s_stb_o, 1'b0);
        chk("idle_m0_ack", m0_ack_o, 1'b0);
        chk("idle_m1_ack", m1_ack_o, 1'b0);
      end else begin
        chk("other_ack", (owner == 0) ? m1_ack_o : m0_ack_o, 1'b0);
        chk("other_err", (owner == 0) ? m1_err_o : m0_err_o, 1'b0);
        chk("other_dat", (owner == 0) ? m1_dat_o : m0_dat_o, 16'h0);
        if (s_ack_i) begin
          chk("owner_ack", (owner == 0) ? m0_ack_o : m1_ack_o, 1'b1);
          chk("owner_dat", (owner == 0) ? m0_dat_o : m1_dat_o, s_dat_i);
          chk("sb_pending", ((owner == 0) ? q0.size() : q1.size()) > 0, 1'b1);
          if (((owner == 0) ? q0.size() : q1.size()) > 0) begin
            mon_e = (owner == 0) ? q0.pop_front() : q1.pop_front();
            chk("s_adr", s_adr_o, mon_e.adr);
            chk("s_dat", s_dat_o, mon_e.dat);
            chk("s_sel", s_sel_o, mon_e.sel);
            chk("s_we", s_we_o, mon_e.we);
            chk("s_cyc_stb", {s_cyc_o, s_stb_o}, 2'b11);
          end
        end
      end
    end
  end

  task automatic drive(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                       input logic we, input logic [1:0] sel, input logic [15:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_sel_i = sel;
      m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_sel_i = sel;
      m1_dat_i = dat;
    end
  endtask

  task automatic wait_ack(input int m);
    int  t;
    bit  got;
    t   = 0;
    got = 1'b0;
    while (!got && t < 300) begin
      @(posedge clk);
      t++;
      got = (m == 0) ? m0_ack_o : m1_ack_o;
      if (got) rdata[m] = (m == 0) ? m0_dat_o : m1_dat_o;
    end
    if (!got) begin
      n_total++;
      $display("FAIL ack_timeout m%0d: got no ack expected ack within 300 cycles", m);
    end
  endtask

  // mode 0: random beats; 1: writes sel=01 to base+2*i; 2: reads at base.
  // Called at posedge+1; returns at posedge+1 with CYC dropped.
  task automatic master_seq(input int m, input int nb, input int mode, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      if (mode == 1) begin
        b.adr = base + 32'(2 * i); b.we = 1'b1; b.sel = 2'b01; b.dat = 16'($urandom);
      end else if (mode == 2) begin
        b.adr = base; b.we = 1'b0; b.sel = 2'b11; b.dat = 16'($urandom);
      end else begin
        b.adr = $urandom; b.we = 1'($urandom); b.sel = 2'($urandom); b.dat = 16'($urandom);
      end
      drive(m, 1'b1, 1'b1, b.adr, b.we, b.sel, b.dat);
      if (m == 0) q0.push_back(b);
      else q1.push_back(b);
      wait_ack(m);
      #1;
    end
    drive(m, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_err, second_err, err_cnt;
    rst_n = 1'b0;
    slave_en = 1'b1; stray_req = 1'b0; fixed_wait = -1; fixed_dat_en = 1'b0; fixed_dat = '0;
    mon_en = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, 1'b0, '0, '0);

    // Reset state, even with a request pending.
    repeat (3) @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 2'b11, 16'h1234);
    #1;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_m0_outs", {m0_ack_o, m0_err_o, m0_dat_o}, 18'h0);
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read with fixed slave latency and data.
    fixed_wait = 2; fixed_dat_en = 1'b1; fixed_dat = 16'hBEEF;
    master_seq(0, 1, 2, 32'h0000_1000);
    chk("read_rdata", rdata[0], 16'hBEEF);
    fixed_wait = -1; fixed_dat_en = 1'b0;

    // Tie straight after reset: master 0 first, then direct handover.
    do_reset();
    fork
      master_seq(0, 2, 0, '0);
      master_seq(1, 1, 0, '0);
      begin
        repeat (2) @(negedge clk);
        chk("tie1_gnt", gnt_o, 2'b01);
      end
    join
    // Master 0 finishes last, so the next tie goes to master 1.
    @(posedge clk); #1;
    master_seq(0, 1, 0, '0);
    @(posedge clk); #1;
    fork
      master_seq(0, 1, 0, '0);
      master_seq(1, 2, 0, '0);
      begin
        repeat (2) @(negedge clk);
        chk("tie2_gnt", gnt_o, 2'b10);
      end
    join

    // Locked 4-beat write by master 1 while master 0 waits.
    @(posedge clk); #1;
    fork
      master_seq(1, 4, 1, 32'h10);
      begin
        repeat (2) begin @(posedge clk); #1; end
        master_seq(0, 1, 0, '0);
      end
    join

    // Stray ACK while idle.
    repeat (2) begin @(posedge clk); #1; end
    stray_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stray_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    chk("stray_gnt", gnt_o, 2'b00);
    @(negedge clk);
    chk("stray_gnt_after", gnt_o, 2'b00);

    // Hung slave.
    @(posedge clk); #1;
    slave_en = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 2'b11, '0);
`ifdef WB_ARB_TIMEOUT_EN
    first_err = -1; second_err = -1; err_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m0_err_o) begin
        err_cnt++;
        if (first_err < 0) first_err = n;
        else second_err = n;
        chk("wd_err_stb", {s_cyc_o, s_stb_o}, 2'b00);
        chk("wd_err_gnt", gnt_o, 2'b01);
      end
      if (n == 11) chk("wd_stb_resumed", s_stb_o, 1'b1);
    end
    chk("wd_first_err", first_err, 10);
    chk("wd_second_err", second_err, 19);
    chk("wd_err_count", err_cnt, 2);
`else
    err_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (m0_err_o || m1_err_o) err_cnt++;
    end
    chk("no_err_1000", err_cnt, 0);
    chk("hang_gnt", gnt_o, 2'b01);
    first_err = 0; second_err = 0;
`endif
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    @(posedge clk); #1;
    slave_en = 1'b1;

    // Asynchronous reset in the middle of a master 1 cycle.
    slave_en = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 2'b10, 16'h5555);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_gnt", gnt_o, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt_o, 2'b00);
    chk("async_rst_s_cyc", s_cyc_o, 1'b0);
    chk("async_rst_s_stb", s_stb_o, 1'b0);
    drive(1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic from both masters.
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        master_seq(0, int'($urandom_range(1, 4)), 0, '0);
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        master_seq(1, int'($urandom_range(1, 4)), 0, '0);
      end
    join
    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
